// File: rtl/sm4_round_engine_if.sv
// SM4 round engine block interface.
// Groups the request/response signals of sm4_round_engine:
//   start_in      request to process one 128-bit block
//   decrypt_in    mode sampled with start_in (0 = encrypt, 1 = decrypt)
//   key_valid_in  round keys on rk_bus_in are complete and stable
//   data_in       input block, word X0 = [127:96]
//   rk_bus_in     32 round keys, rk_i = [32*i+31:32*i]
//   busy_out      rounds in progress
//   done_out      one-cycle pulse, data_out valid
//   data_out      result block, held until the next done_out
// The master drives the requests; the engine is the slave.
interface sm4_round_engine_if;
    logic          start_in;
    logic          decrypt_in;
    logic          key_valid_in;
    logic [127:0]  data_in;
    logic [1023:0] rk_bus_in;
    logic          busy_out;
    logic          done_out;
    logic [127:0]  data_out;

    modport master (
        output start_in, decrypt_in, key_valid_in, data_in, rk_bus_in,
        input  busy_out, done_out, data_out
    );

    modport slave (
        input  start_in, decrypt_in, key_valid_in, data_in, rk_bus_in,
        output busy_out, done_out, data_out
    );
endinterface

// File: rtl/sm4_round_engine.sv
// SM4 iterative round engine: one SM4 round per clock, 32 rounds per block.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    sm4_round_engine_if slave modport (start/mode/keys/data in,
//          busy/done/result out)
// A block accepted in IDLE (start_in with key_valid_in) is processed in
// ROUND for 32 edges; the final edge writes the word-reversed state to
// data_out and pulses done_out. Round keys are read straight off the bus
// each round; the key schedule upstream keeps them stable while busy.
module sm4_round_engine (
    input  logic              clk,
    input  logic              reset,
    sm4_round_engine_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ROUND = 1'b1
    } state_e;

    // Standard SM4 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // Combinational 256x8 lookup; byte a sits at bits [2047-8a -: 8].
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [10:0] base_s;
        base_s = 11'd2047 - {a, 3'd0};
        return SBOX_TABLE[base_s -: 8];
    endfunction

    state_e        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [127:0]  x_q, x_d;
    logic          dec_q, dec_d;
    logic          done_q, done_d;
    logic [127:0]  dout_q, dout_d;

    logic [4:0]    key_idx_s;
    logic [31:0]   rk_s;
    logic [31:0]   mix_in_s;
    logic [31:0]   tau_s;
    logic [31:0]   t_out_s;
    logic [127:0]  round_out_s;

    // One full SM4 round on the current state; decryption walks the keys backwards.
    always_comb begin
        key_idx_s   = dec_q ? (5'd31 - cnt_q) : cnt_q;
        rk_s        = bus.rk_bus_in[{key_idx_s, 5'd0} +: 32];
        mix_in_s    = x_q[95:64] ^ x_q[63:32] ^ x_q[31:0] ^ rk_s;
        tau_s       = {sbox(mix_in_s[31:24]), sbox(mix_in_s[23:16]),
                       sbox(mix_in_s[15:8]),  sbox(mix_in_s[7:0])};
        t_out_s     = tau_s
                    ^ {tau_s[29:0], tau_s[31:30]}
                    ^ {tau_s[21:0], tau_s[31:22]}
                    ^ {tau_s[13:0], tau_s[31:14]}
                    ^ {tau_s[7:0],  tau_s[31:8]};
        round_out_s = {x_q[95:0], x_q[127:96] ^ t_out_s};
    end

    // Next-state and datapath control for the IDLE/ROUND machine.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE: begin
                // Starts without valid keys are dropped, not remembered.
                if (bus.start_in && bus.key_valid_in) begin
                    x_d     = bus.data_in;
                    dec_d   = bus.decrypt_in;
                    cnt_d   = 5'd0;
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROUND: begin
                x_d   = round_out_s;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    // Output is the final four words in reverse order.
                    dout_d  = {round_out_s[31:0], round_out_s[63:32],
                               round_out_s[95:64], round_out_s[127:96]};
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            x_q     <= 128'h0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= 128'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.busy_out = (state_q == ST_ROUND);
    assign bus.done_out = done_q;
    assign bus.data_out = dout_q;

endmodule
